// File: rtl/vc_stream_mux_arb_if.sv
// Handshake bundle for the N-input stream mux: p_nin producer channels in, one consumer stream out.
interface vc_stream_mux_arb_if #(
   parameter int p_nbits = 32,
   parameter int p_nin   = 4
);
   localparam int c_sbits = $clog2(p_nin);

   logic [p_nin-1:0]         in_val;
   logic [p_nin-1:0]         in_rdy;
   logic [p_nin*p_nbits-1:0] in_msg;
   logic                     out_val;
   logic                     out_rdy;
   logic [p_nbits-1:0]       out_msg;
   logic [c_sbits-1:0]       out_sel;

   modport master (
      output in_val, in_msg, out_rdy,
      input  in_rdy, out_val, out_msg, out_sel
   );

   modport slave (
      input  in_val, in_msg, out_rdy,
      output in_rdy, out_val, out_msg, out_sel
   );
endinterface

// File: rtl/vc_stream_mux_arb.sv
// N-input val/rdy stream mux with fixed-priority or round-robin arbitration into a one-entry
// output register; accepts and drains in the same cycle for 1 msg/cycle throughput.
module vc_stream_mux_arb #(
   parameter int p_nbits = 32,
   parameter int p_nin   = 4,
   parameter int p_rr    = 1
) (
   input  logic               clk,
   input  logic               reset,
   vc_stream_mux_arb_if.slave bus
);
   localparam int c_sbits = $clog2(p_nin);

   generate
      if (p_nin < 2 || p_nin > 8) begin : g_bad_nin
         $error("vc_stream_mux_arb: p_nin must be in 2..8");
      end
      if (p_nbits < 1) begin : g_bad_nbits
         $error("vc_stream_mux_arb: p_nbits must be >= 1");
      end
   endgenerate

   logic [p_nin-1:0]   grant;
   logic [c_sbits-1:0] sel;
   logic [c_sbits-1:0] ptr;
   logic               free;
   logic               accept;
   logic [p_nbits-1:0] msg_arr [p_nin];

   for (genvar i = 0; i < p_nin; i++) begin : g_msg
      assign msg_arr[i] = bus.in_msg[i*p_nbits +: p_nbits];
   end

   // Walk from the highest search offset down so the nearest valid channel to ptr wins last.
   always_comb begin
      logic [c_sbits:0]   sum;
      logic [c_sbits-1:0] idx;
      grant = '0;
      sum   = '0;
      idx   = '0;
      for (int j = p_nin - 1; j >= 0; j--) begin
         sum = {1'b0, ptr} + (c_sbits+1)'(j);
         if (sum >= (c_sbits+1)'(p_nin)) sum = sum - (c_sbits+1)'(p_nin);
         idx = sum[c_sbits-1:0];
         if (bus.in_val[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
         end
      end
   end

   always_comb begin
      sel = '0;
      for (int i = 0; i < p_nin; i++) begin
         if (grant[i]) sel = c_sbits'(i);
      end
   end

   assign free       = !bus.out_val || bus.out_rdy;
   assign bus.in_rdy = grant & {p_nin{free && reset}};
   assign accept     = |(bus.in_val & bus.in_rdy);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_val <= 1'b0;
         bus.out_msg <= '0;
         bus.out_sel <= '0;
      end else if (accept) begin
         bus.out_val <= 1'b1;
         bus.out_msg <= msg_arr[sel];
         bus.out_sel <= sel;
      end else if (bus.out_rdy) begin
         bus.out_val <= 1'b0;
      end
   end

   generate
      if (p_rr != 0) begin : g_rr
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               ptr <= '0;
            end else if (accept) begin
               ptr <= (sel == c_sbits'(p_nin - 1)) ? '0 : sel + c_sbits'(1);
            end
         end
      end else begin : g_fixed
         assign ptr = '0;
      end
   endgenerate
endmodule

// File: tb/tb_vc_stream_mux_arb.sv
// Directed bench: expected outputs are queued by the stimulus and popped by per-DUT monitors.
module tb_vc_stream_mux_arb;
   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] msg;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q_rr[$];
   exp_t q_fx[$];

   vc_stream_mux_arb_if #(.p_nbits(8), .p_nin(4)) br ();
   vc_stream_mux_arb_if #(.p_nbits(8), .p_nin(4)) bf ();

   vc_stream_mux_arb #(.p_nbits(8), .p_nin(4), .p_rr(1)) u_rr (
      .clk(clk), .reset(reset), .bus(br.slave)
   );
   vc_stream_mux_arb #(.p_nbits(8), .p_nin(4), .p_rr(0)) u_fx (
      .clk(clk), .reset(reset), .bus(bf.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_rr(input logic [1:0] s, input logic [7:0] m);
      q_rr.push_back({s, m});
   endtask

   task automatic push_fx(input logic [1:0] s, input logic [7:0] m);
      q_fx.push_back({s, m});
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1 && br.out_val && br.out_rdy) begin
         exp_t e;
         n_chk++;
         if (q_rr.size() == 0) begin
            n_fail++;
            $display("FAIL rr_unexpected: got sel=%0d msg=%h expected none", br.out_sel, br.out_msg);
         end else begin
            e = q_rr.pop_front();
            if (br.out_sel !== e.sel || br.out_msg !== e.msg) begin
               n_fail++;
               $display("FAIL rr_out: got sel=%0d msg=%h expected sel=%0d msg=%h",
                        br.out_sel, br.out_msg, e.sel, e.msg);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1 && bf.out_val && bf.out_rdy) begin
         exp_t e;
         n_chk++;
         if (q_fx.size() == 0) begin
            n_fail++;
            $display("FAIL fx_unexpected: got sel=%0d msg=%h expected none", bf.out_sel, bf.out_msg);
         end else begin
            e = q_fx.pop_front();
            if (bf.out_sel !== e.sel || bf.out_msg !== e.msg) begin
               n_fail++;
               $display("FAIL fx_out: got sel=%0d msg=%h expected sel=%0d msg=%h",
                        bf.out_sel, bf.out_msg, e.sel, e.msg);
            end
         end
      end
   end

   // Unknown valids while out of reset would corrupt the rr pointer.
   always @(negedge clk) begin
      if (reset === 1'b1)
         assert (!$isunknown(br.in_val) && !$isunknown(bf.in_val))
         else $error("in_val unknown while out of reset");
   end

   initial begin
      reset      = 1'b0;
      br.in_val  = 4'b1111;
      br.in_msg  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      br.out_rdy = 1'b1;
      bf.in_val  = 4'b0000;
      bf.in_msg  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
      bf.out_rdy = 1'b1;

      // reset held with all inputs valid
      tick();
      tick();
      #1;
      chk("rst_out_val", br.out_val, 0);
      chk("rst_in_rdy", br.in_rdy, 4'b0000);
      chk("rst_out_sel", br.out_sel, 0);
      chk("rst_out_msg", br.out_msg, 0);
      reset = 1'b1;
      #1;
      chk("first_grant", br.in_rdy, 4'b0001);

      // round-robin fairness at full throughput
      push_rr(2'd0, 8'hA0);
      push_rr(2'd1, 8'hA1);
      push_rr(2'd2, 8'hA2);
      push_rr(2'd3, 8'hA3);
      push_rr(2'd0, 8'hA0);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 4) br.in_val = 4'b0000;
         chk($sformatf("tput_val%0d", i), br.out_val, 1);
      end
      tick();
      chk("drain_val", br.out_val, 0);

      // backpressure, then drain and accept in one cycle
      br.in_msg[15:8] = 8'h55;
      br.in_val       = 4'b0010;
      br.out_rdy      = 1'b0;
      push_rr(2'd1, 8'h55);
      tick();
      br.in_val = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         #1;
         chk($sformatf("stall_val%0d", i), br.out_val, 1);
         chk($sformatf("stall_msg%0d", i), br.out_msg, 8'h55);
         chk($sformatf("stall_sel%0d", i), br.out_sel, 1);
         chk($sformatf("stall_rdy%0d", i), br.in_rdy, 4'b0000);
      end
      br.out_rdy = 1'b1;
      #1;
      chk("drain_acc_rdy", br.in_rdy, 4'b0100);
      push_rr(2'd2, 8'hA2);
      tick();
      chk("drain_acc_val", br.out_val, 1);
      chk("drain_acc_msg", br.out_msg, 8'hA2);
      chk("drain_acc_sel", br.out_sel, 2);

      // pointer wrap from 3 back to 0
      br.in_val = 4'b1001;
      push_rr(2'd3, 8'hA3);
      push_rr(2'd0, 8'hA0);
      #1;
      chk("wrap_grant3", br.in_rdy, 4'b1000);
      tick();
      #1;
      chk("wrap_grant0", br.in_rdy, 4'b0001);
      tick();
      br.in_val = 4'b0001;
      push_rr(2'd0, 8'hA0);
      #1;
      chk("only_ch0", br.in_rdy, 4'b0001);
      tick();
      br.in_val = 4'b0000;
      tick();

      // async reset while a message is stalled in the register
      br.out_rdy = 1'b0;
      br.in_val  = 4'b0100;
      tick();
      br.in_val = 4'b0000;
      #1;
      chk("held_val", br.out_val, 1);
      chk("held_msg", br.out_msg, 8'hA2);
      #1;
      reset = 1'b0;
      #1;
      chk("async_out_val", br.out_val, 0);
      chk("async_out_msg", br.out_msg, 0);
      chk("async_out_sel", br.out_sel, 0);
      chk("async_in_rdy", br.in_rdy, 4'b0000);
      br.in_val  = 4'b1111;
      br.out_rdy = 1'b1;
      tick();
      reset = 1'b1;
      #1;
      chk("ptr_after_reset", br.in_rdy, 4'b0001);
      chk("release_no_out", br.out_val, 0);
      br.in_val = 4'b0000;

      // fixed priority: lowest valid index always wins
      bf.in_val = 4'b0110;
      for (int i = 0; i < 4; i++) begin
         push_fx(2'd1, 8'hB1);
         #1;
         chk($sformatf("fx_rdy%0d", i), bf.in_rdy, 4'b0010);
         tick();
      end
      bf.in_val = 4'b0000;
      chk("fx_last_msg", bf.out_msg, 8'hB1);
      tick();
      tick();
      tick();

      chk("rr_queue_empty", q_rr.size(), 0);
      chk("fx_queue_empty", q_fx.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
